shift_ram: RTL and testbench

Parametrised word-addressable memory block with in-place, multi-cycle word shifting. It holds 2**ADDRS words of BLOCK_SIZE bits. It serves single-cycle writes, registered reads, and shift-by-N operations: a word is loaded, shifted one bit per cycle with a serial fill bit, and written back. It sits between the datapath bus controller and the storage it manages, and is the next generation of the team's RAM block: split data buses, a shift engine, a busy/done handshake and a last-shifted-bit output.

---
 rtl/shift_ram.sv | 136 +++++++++++++
 tb/tb_shift_ram.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/shift_ram.sv
// Word-addressable memory with single-cycle writes, registered reads and
// an in-place multi-cycle shift engine (load, shift one bit per edge, write back).
//
// state | meaning
// IDLE  | accepting commands
// LOAD  | fetch target word into the work register
// SHIFT | one bit per edge, count runs down to zero
// WB    | write the shifted word back, pulse done
module shift_ram #(
  parameter int ADDRS      = 4,
  parameter int BLOCK_SIZE = 8,
  parameter int CNT_W      = $clog2(BLOCK_SIZE + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cs,
  input  logic                  we,
  input  logic                  re,
  input  logic                  se,
  input  logic                  sd,
  input  logic                  si,
  input  logic [CNT_W-1:0]      sh_cnt,
  input  logic [ADDRS-1:0]      addr,
  input  logic [BLOCK_SIZE-1:0] din,
  output logic [BLOCK_SIZE-1:0] dout,
  output logic                  dout_valid,
  output logic                  ls,
  output logic                  busy,
  output logic                  done
);

  localparam int DEPTH = 2 ** ADDRS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    WB    = 2'd3
  } state_t;

  logic [BLOCK_SIZE-1:0] mem [DEPTH];

  state_t                state;
  logic [ADDRS-1:0]      addr_q;
  logic                  sd_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [BLOCK_SIZE-1:0] work;

  logic                  accept;
  logic                  cmd_we;
  logic                  cmd_se;
  logic                  cmd_re;
  logic [CNT_W-1:0]      sat_cnt;

  // Priority we > se > re; only one command per accept edge.
  assign accept  = cs && (state == IDLE);
  assign cmd_we  = accept && we;
  assign cmd_se  = accept && !we && se;
  assign cmd_re  = accept && !we && !se && re;
  assign sat_cnt = (sh_cnt > CNT_W'(BLOCK_SIZE)) ? CNT_W'(BLOCK_SIZE) : sh_cnt;

  // Storage is never reset; reset only blocks writes so an abandoned shift leaves the word intact.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (cmd_we) begin
        mem[addr] <= din;
      end else if (state == WB) begin
        mem[addr_q] <= work;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      addr_q     <= '0;
      sd_q       <= 1'b0;
      cnt_q      <= '0;
      work       <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      ls         <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      dout_valid <= cmd_re;
      done       <= 1'b0;
      if (cmd_re) begin
        dout <= mem[addr];
      end

      case (state)
        IDLE: begin
          if (cmd_se) begin
            addr_q <= addr;
            sd_q   <= sd;
            cnt_q  <= sat_cnt;
            busy   <= 1'b1;
            state  <= LOAD;
          end
        end

        LOAD: begin
          work  <= mem[addr_q];
          state <= (cnt_q != '0) ? SHIFT : WB;
        end

        SHIFT: begin
          if (sd_q) begin
            work <= {si, work[BLOCK_SIZE-1:1]};
            ls   <= work[0];
          end else begin
            work <= {work[BLOCK_SIZE-2:0], si};
            ls   <= work[BLOCK_SIZE-1];
          end
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state <= WB;
          end
        end

        WB: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_ram.sv
// Bench for shift_ram: directed vector table, reset/priority sequences and
// randomized traffic against an arithmetic word-level model.
module tb_shift_ram;

  localparam int B = 8;
  localparam int A = 4;
  localparam int CW = $clog2(B + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cs = 1'b0, we = 1'b0, re = 1'b0, se = 1'b0, sd = 1'b0, si = 1'b0;
  logic [CW-1:0] sh_cnt = '0;
  logic [A-1:0]  addr = '0;
  logic [B-1:0]  din = '0;
  logic [B-1:0]  dout;
  logic          dout_valid, ls, busy, done;

  shift_ram #(.ADDRS(A), .BLOCK_SIZE(B)) dut (
    .clk(clk), .rst(rst), .cs(cs), .we(we), .re(re), .se(se), .sd(sd), .si(si),
    .sh_cnt(sh_cnt), .addr(addr), .din(din), .dout(dout), .dout_valid(dout_valid),
    .ls(ls), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [B-1:0] m_mem [16];
  bit           m_ls = 1'b0;

  typedef struct {
    int op;     // 0 write, 1 read, 2 shift
    int a;
    int d;      // write data / read expectation
    int sd;
    int si;     // 0/1 constant fill, 2 random
    int cnt;
    int noise;  // shift only: address hit by ignored commands, -1 none
    int exp_ls; // shift only: -1 skip
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input int a, input int d);
    cs = 1; we = 1; addr = A'(a); din = B'(d);
    tick();
    cs = 0; we = 0;
    m_mem[a] = B'(d);
    chk("write_no_busy", int'(busy), 0);
  endtask

  task automatic do_read(input int a, input int exp);
    cs = 1; re = 1; addr = A'(a);
    tick();
    cs = 0; re = 0;
    chk("read_valid", int'(dout_valid), 1);
    chk("read_data", int'(dout), exp);
    tick();
    chk("read_valid_pulse", int'(dout_valid), 0);
  endtask

  task automatic do_shift(input int a, input int dir, input int cnt, input int simode, input int noise_a);
    int si_hist [64];
    int n, bc, k;
    logic [B-1:0] orig, res;
    n    = (cnt > B) ? B : cnt;
    orig = m_mem[a];
    cs = 1; se = 1; we = 0; re = 0; addr = A'(a); sd = dir[0]; sh_cnt = CW'(cnt);
    tick();
    // scramble latched inputs; the operation must not notice
    se = 0; cs = 0; addr = A'($urandom); sd = 1'($urandom); sh_cnt = CW'($urandom_range(0, 15));
    bc = 0; k = 0;
    while (busy && bc < 40) begin
      bc++;
      si = (simode == 2) ? 1'($urandom) : simode[0];
      si_hist[k] = int'(si);
      k++;
      if (noise_a >= 0) begin
        cs = 1; we = 1'($urandom); re = ~we; addr = A'(noise_a); din = B'($urandom);
      end
      chk("busy_no_done", int'(done), 0);
      chk("busy_no_dout_valid", int'(dout_valid), 0);
      tick();
    end
    cs = 0; we = 0; re = 0;
    chk("shift_busy_cycles", bc, n + 2);
    chk("shift_done", int'(done), 1);
    // word-level model: shift by n, fill bits in order of sampling (index j = shift j)
    res = orig;
    if (n > 0) begin
      if (dir == 0) begin
        res   = B'(orig << n);
        m_ls  = orig[B - n];
        for (int j = 1; j <= n; j++) res = res | B'(si_hist[j] << (n - j));
      end else begin
        res   = B'(orig >> n);
        m_ls  = orig[n - 1];
        for (int j = 1; j <= n; j++) res = res | B'(si_hist[j] << (B - 1 - (n - j)));
      end
    end
    m_mem[a] = res;
    chk("shift_ls", int'(ls), int'(m_ls));
    tick();
    chk("done_pulse", int'(done), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    tbl.push_back('{0, 3, 'hA5, 0, 0, 0, -1, -1});
    tbl.push_back('{1, 3, 'hA5, 0, 0, 0, -1, -1});
    tbl.push_back('{0, 2, 'h81, 0, 0, 0, -1, -1});
    tbl.push_back('{2, 2, 0,    0, 0, 1, -1,  1});
    tbl.push_back('{1, 2, 'h02, 0, 0, 0, -1, -1});
    tbl.push_back('{0, 5, 'h81, 0, 0, 0, -1, -1});
    tbl.push_back('{2, 5, 0,    1, 1, 3, -1,  0});
    tbl.push_back('{1, 5, 'hF0, 0, 0, 0, -1, -1});
    tbl.push_back('{0, 9, 'h5A, 0, 0, 0, -1, -1});
    tbl.push_back('{0, 7, 'h00, 0, 0, 0, -1, -1});
    tbl.push_back('{2, 7, 0,    0, 1, 15, 9,  0});
    tbl.push_back('{1, 7, 'hFF, 0, 0, 0, -1, -1});
    tbl.push_back('{1, 9, 'h5A, 0, 0, 0, -1, -1});
    tbl.push_back('{2, 2, 0,    0, 1, 0, -1, -1});
    tbl.push_back('{1, 2, 'h02, 0, 0, 0, -1, -1});

    tick();
    tick();
    chk("rst_dout", int'(dout), 0);
    chk("rst_dout_valid", int'(dout_valid), 0);
    chk("rst_ls", int'(ls), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    rst = 0;
    tick();

    foreach (tbl[i]) begin
      case (tbl[i].op)
        0: do_write(tbl[i].a, tbl[i].d);
        1: do_read(tbl[i].a, tbl[i].d);
        default: begin
          do_shift(tbl[i].a, tbl[i].sd, tbl[i].cnt, tbl[i].si, tbl[i].noise);
          if (tbl[i].exp_ls >= 0) chk("table_ls", int'(ls), tbl[i].exp_ls);
        end
      endcase
    end

    // we+se+re together: only the write happens
    cs = 1; we = 1; se = 1; re = 1; addr = 4; din = 'h11; sh_cnt = 3;
    tick();
    cs = 0; we = 0; se = 0; re = 0;
    m_mem[4] = 'h11;
    chk("prio_no_busy", int'(busy), 0);
    chk("prio_no_dout_valid", int'(dout_valid), 0);
    tick();
    chk("prio_no_busy_later", int'(busy), 0);
    do_read(4, 'h11);

    // reset in the middle of a right shift of 0x3C
    do_write(6, 'h3C);
    cs = 1; se = 1; addr = 6; sd = 1; sh_cnt = 5; si = 1;
    tick();
    cs = 0; se = 0;
    for (int j = 0; j < 4; j++) tick();
    chk("midshift_busy", int'(busy), 1);
    chk("midshift_ls", int'(ls), 1);
    rst = 1;
    tick();
    rst = 0;
    m_ls = 0;
    chk("rstshift_busy", int'(busy), 0);
    chk("rstshift_ls", int'(ls), 0);
    chk("rstshift_done", int'(done), 0);
    tick();
    chk("rstshift_no_done", int'(done), 0);
    chk("rstshift_idle", int'(busy), 0);
    do_read(6, 'h3C);

    // randomized traffic against the model
    for (int a = 0; a < 16; a++) do_write(a, int'($urandom_range(0, 255)));
    for (int t = 0; t < 80; t++) begin
      int a, op;
      a  = int'($urandom_range(0, 15));
      op = int'($urandom_range(0, 2));
      case (op)
        0: do_write(a, int'($urandom_range(0, 255)));
        1: do_read(a, int'(m_mem[a]));
        default: do_shift(a, int'($urandom_range(0, 1)), int'($urandom_range(0, 15)), 2, -1);
      endcase
    end
    for (int a = 0; a < 16; a++) do_read(a, int'(m_mem[a]));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
